// File: rtl/ifm_feeder_pkg.sv
// ifm_feeder_pkg: shared state encoding, pixel type and default widths for the IFM path.
package ifm_feeder_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DIM_W  = 6;

  typedef logic signed [7:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ifm_skid_stage.sv
// ifm_skid_stage: one-entry skid register plus the registered byte-stream outputs.
// A byte returning from the SRAM while downstream is stalled parks in the skid entry
// and is replayed on the first unstalled cycle, ahead of any newer read data.
module ifm_skid_stage
  import ifm_feeder_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   rd_valid,
  input  pixel_t rd_data,
  input  logic   rd_row_start,
  output logic   skid_valid,
  output pixel_t ifm_input,
  output logic   ifm_read,
  output logic   ifm_row_start
);

  logic   skid_valid_q, skid_valid_d;
  pixel_t skid_data_q, skid_data_d;
  logic   skid_row_q, skid_row_d;
  logic   read_q, read_d;
  pixel_t input_q, input_d;
  logic   row_start_q, row_start_d;

  // Next-value logic: park returning data on stall, otherwise emit skid first, then fresh data.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_row_d   = skid_row_q;
    read_d       = 1'b0;
    input_d      = input_q;
    row_start_d  = 1'b0;
    if (stall) begin
      if (rd_valid) begin
        skid_valid_d = 1'b1;
        skid_data_d  = rd_data;
        skid_row_d   = rd_row_start;
      end
    end else begin
      read_d       = skid_valid_q | rd_valid;
      input_d      = skid_valid_q ? skid_data_q : rd_data;
      row_start_d  = skid_valid_q ? skid_row_q : (rd_valid & rd_row_start);
      skid_valid_d = 1'b0;
    end
  end

  // Skid entry and output registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_row_q   <= 1'b0;
      read_q       <= 1'b0;
      input_q      <= '0;
      row_start_q  <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_row_q   <= skid_row_d;
      read_q       <= read_d;
      input_q      <= input_d;
      row_start_q  <= row_start_d;
    end
  end

  assign skid_valid    = skid_valid_q;
  assign ifm_read      = read_q;
  assign ifm_input     = input_q;
  assign ifm_row_start = row_start_q;

endmodule

// File: rtl/ifm_feeder.sv
// ifm_feeder: walks one image out of the IFM SRAM in row-major order and feeds the
// bytes to the IFM shift buffer, honouring a downstream stall without loss.
module ifm_feeder
  import ifm_feeder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic              stall,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  pixel_t            sram_rdata,
  output pixel_t            ifm_input,
  output logic              ifm_read,
  output logic              ifm_row_start,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_row_start_q, rd_row_start_d;
  logic              skid_valid;
  logic              last_col;
  logic              last_row;

  assign last_col = (col_q == width_q - DIM_W'(1));
  assign last_row = (row_q == height_q - DIM_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start seen outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (cfg_width != '0 && cfg_height != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (sram_en && last_col && last_row) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rd_valid_q && !skid_valid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: reads issue only on unstalled FETCH cycles.
  always_comb begin
    sram_en = (state_q == ST_FETCH) && !stall;
    busy    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    done    = (state_q == ST_DONE);
  end

  // Address walk: a running address plus column/row counters replaces base+row*width+col.
  always_comb begin
    addr_d         = addr_q;
    col_d          = col_q;
    row_d          = row_q;
    width_d        = width_q;
    height_d       = height_q;
    rd_valid_d     = sram_en;
    rd_row_start_d = sram_en && (col_q == '0);
    if (state_q == ST_IDLE && start) begin
      addr_d   = cfg_base;
      col_d    = '0;
      row_d    = '0;
      width_d  = cfg_width;
      height_d = cfg_height;
    end else if (sram_en) begin
      addr_d = addr_q + ADDR_W'(1);
      if (last_col) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  // Address counters, latched config and the in-flight read flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      width_q        <= '0;
      height_q       <= '0;
      rd_valid_q     <= 1'b0;
      rd_row_start_q <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      col_q          <= col_d;
      row_q          <= row_d;
      width_q        <= width_d;
      height_q       <= height_d;
      rd_valid_q     <= rd_valid_d;
      rd_row_start_q <= rd_row_start_d;
    end
  end

  assign sram_addr = addr_q;

  ifm_skid_stage u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .rd_valid     (rd_valid_q),
    .rd_data      (sram_rdata),
    .rd_row_start (rd_row_start_q),
    .skid_valid   (skid_valid),
    .ifm_input    (ifm_input),
    .ifm_read     (ifm_read),
    .ifm_row_start(ifm_row_start)
  );

endmodule

// File: tb/tb_ifm_feeder.sv
// tb_ifm_feeder: table-driven image runs against a queue-based model of the expected
// address list and byte stream, plus hand-written reset and restart sequences.
module tb_ifm_feeder;
  import ifm_feeder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] cfg_base = '0;
  logic [5:0]  cfg_width = '0;
  logic [5:0]  cfg_height = '0;
  logic        stall = 1'b0;
  logic        sram_en;
  logic [11:0] sram_addr;
  pixel_t      sram_rdata = '0;
  pixel_t      ifm_input;
  logic        ifm_read;
  logic        ifm_row_start;
  logic        busy;
  logic        done;

  typedef struct {
    logic [11:0] base;
    logic [5:0]  w;
    logic [5:0]  h;
    int          stall_pct;
    int          stall_from;
    int          stall_len;
    bit          restart;
    int          exp_reads;
    logic [11:0] exp_last;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [11:0] got_addr[$];
  int          en_cyc[$];
  logic [7:0]  got_byte[$];
  bit          got_rs[$];
  int          rd_cyc[$];
  int          done_cyc[$];
  int          busy_cnt = 0;
  int          orphan_rs = 0;

  ifm_feeder #(.ADDR_W(12), .DIM_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_base     (cfg_base),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .stall        (stall),
    .sram_en      (sram_en),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .ifm_input    (ifm_input),
    .ifm_read     (ifm_read),
    .ifm_row_start(ifm_row_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used to time-stamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], 4'hA};
  endfunction

  // SRAM model: requested byte one cycle after sram_en, random junk otherwise.
  always @(posedge clk) begin
    if (sram_en) sram_rdata <= $signed(mem_byte(sram_addr));
    else sram_rdata <= $signed(8'($urandom));
  end

  // Monitor: record every DUT event mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sram_en) begin
      got_addr.push_back(sram_addr);
      en_cyc.push_back(cyc);
    end
    if (ifm_read) begin
      got_byte.push_back(ifm_input);
      got_rs.push_back(ifm_row_start);
      rd_cyc.push_back(cyc);
    end else if (ifm_row_start) begin
      orphan_rs++;
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_addr.delete();
    en_cyc.delete();
    got_byte.delete();
    got_rs.delete();
    rd_cyc.delete();
    done_cyc.delete();
    busy_cnt = 0;
    orphan_rs = 0;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Launch one image and drive the stall pattern until done or the cycle budget expires.
  task automatic apply_stimulus(input vec_t v, output int s_cyc);
    int budget;
    clear_mon();
    cfg_base   = v.base;
    cfg_width  = v.w;
    cfg_height = v.h;
    start      = 1'b1;
    tick();
    start = 1'b0;
    s_cyc = cyc;
    budget = 0;
    while (done_cyc.size() == 0 && budget < 2000) begin
      if (v.stall_pct > 0) stall = ($urandom_range(99) < v.stall_pct);
      else stall = (budget >= v.stall_from && budget < v.stall_from + v.stall_len);
      if (v.restart && budget == 2) begin
        cfg_base   = 12'h300;
        cfg_width  = 6'd5;
        cfg_height = 6'd5;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      budget++;
    end
    stall = 1'b0;
    start = 1'b0;
    repeat (3) tick();
  endtask

  // Compare everything recorded for one image against the model derived from its config.
  task automatic verify_image(input int idx, input vec_t v, input int s_cyc);
    int n;
    bit no_stall;
    no_stall = (v.stall_pct == 0) && (v.stall_len == 0);
    check_output($sformatf("v%0d done_pulses", idx), done_cyc.size(), 1);
    check_output($sformatf("v%0d sram_en_count", idx), got_addr.size(), v.exp_reads);
    check_output($sformatf("v%0d ifm_read_count", idx), got_byte.size(), v.exp_reads);
    check_output($sformatf("v%0d orphan_row_start", idx), orphan_rs, 0);
    n = (got_addr.size() < v.exp_reads) ? got_addr.size() : v.exp_reads;
    for (int k = 0; k < n; k++)
      check_output($sformatf("v%0d addr[%0d]", idx, k), got_addr[k], 12'(v.base + k));
    n = (got_byte.size() < v.exp_reads) ? got_byte.size() : v.exp_reads;
    for (int k = 0; k < n; k++) begin
      check_output($sformatf("v%0d byte[%0d]", idx, k), got_byte[k], mem_byte(12'(v.base + k)));
      check_output($sformatf("v%0d row_start[%0d]", idx, k), got_rs[k], (k % v.w) == 0);
    end
    if (v.exp_reads > 0 && got_addr.size() > 0)
      check_output($sformatf("v%0d last_addr", idx), got_addr[got_addr.size()-1], v.exp_last);
    if (v.exp_reads == 0) begin
      check_output($sformatf("v%0d busy_cycles", idx), busy_cnt, 0);
      if (done_cyc.size() > 0)
        check_output($sformatf("v%0d done_cycle", idx), done_cyc[0], s_cyc);
    end else if (no_stall) begin
      if (en_cyc.size() > 0)
        check_output($sformatf("v%0d first_en_cycle", idx), en_cyc[0], s_cyc);
      n = (en_cyc.size() < rd_cyc.size()) ? en_cyc.size() : rd_cyc.size();
      for (int k = 0; k < n; k++)
        check_output($sformatf("v%0d latency[%0d]", idx, k), rd_cyc[k] - en_cyc[k], 2);
      if (done_cyc.size() > 0 && rd_cyc.size() > 0)
        check_output($sformatf("v%0d done_after_last", idx), done_cyc[0], rd_cyc[rd_cyc.size()-1] + 1);
    end
  endtask

  initial begin
    vec_t vecs[10];
    int   s_cyc;

    vecs[0] = '{12'h010, 6'd3, 6'd2, 0, 0, 0, 1'b0, 6, 12'h015};
    vecs[1] = '{12'hFFE, 6'd2, 6'd2, 0, 0, 0, 1'b0, 4, 12'h001};
    vecs[2] = '{12'h100, 6'd4, 6'd4, 0, 5, 3, 1'b0, 16, 12'h10F};
    vecs[3] = '{12'h020, 6'd0, 6'd5, 0, 0, 0, 1'b0, 0, 12'h000};
    vecs[4] = '{12'h030, 6'd4, 6'd0, 0, 0, 0, 1'b0, 0, 12'h000};
    vecs[5] = '{12'h040, 6'd3, 6'd2, 0, 0, 0, 1'b1, 6, 12'h045};
    vecs[6] = '{12'h07F, 6'd1, 6'd3, 0, 0, 0, 1'b0, 3, 12'h081};
    for (int i = 7; i < 10; i++) begin
      vecs[i].base       = 12'($urandom);
      vecs[i].w          = 6'($urandom_range(7, 1));
      vecs[i].h          = 6'($urandom_range(5, 1));
      vecs[i].stall_pct  = 40;
      vecs[i].stall_from = 0;
      vecs[i].stall_len  = 0;
      vecs[i].restart    = 1'b0;
      vecs[i].exp_reads  = int'(vecs[i].w) * int'(vecs[i].h);
      vecs[i].exp_last   = 12'(int'(vecs[i].base) + vecs[i].exp_reads - 1);
    end

    rst_n = 1'b0;
    repeat (3) tick();
    check_output("reset sram_en", sram_en, 0);
    check_output("reset sram_addr", sram_addr, 0);
    check_output("reset ifm_read", ifm_read, 0);
    check_output("reset ifm_input", ifm_input, 0);
    check_output("reset ifm_row_start", ifm_row_start, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i], s_cyc);
      verify_image(i, vecs[i], s_cyc);
    end

    clear_mon();
    cfg_base   = 12'h200;
    cfg_width  = 6'd4;
    cfg_height = 6'd4;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check_output("midreset busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    check_output("midreset sram_en", sram_en, 0);
    check_output("midreset sram_addr", sram_addr, 0);
    check_output("midreset ifm_read", ifm_read, 0);
    check_output("midreset ifm_input", ifm_input, 0);
    check_output("midreset ifm_row_start", ifm_row_start, 0);
    check_output("midreset busy", busy, 0);
    check_output("midreset done", done, 0);
    rst_n = 1'b1;
    clear_mon();
    repeat (6) tick();
    check_output("midreset no_done_after", done_cyc.size(), 0);
    check_output("midreset no_reads_after", got_addr.size(), 0);
    apply_stimulus(vecs[0], s_cyc);
    verify_image(10, vecs[0], s_cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifm_feeder.md
IFM_FEEDER -- requirements
Module: ifm_feeder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, IFM SRAM address width.
REQ-002 SHALL have parameter DIM_W, default 6, width of the image-dimension configuration fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to stream one image.
REQ-006 SHALL have ports cfg_base (input, ADDR_W), cfg_width (input, DIM_W) and cfg_height (input, DIM_W), sampled only on an accepted start.
REQ-007 SHALL have port stall, input, 1, downstream hold; stall=1 at edge t forces ifm_read=0 after edge t+1.
REQ-008 SHALL have ports sram_en (output, 1) and sram_addr (output, ADDR_W), the IFM SRAM read request.
REQ-009 SHALL have port sram_rdata, input, signed 8, valid exactly one cycle after sram_en.
REQ-010 SHALL have ports ifm_input (output, signed 8) and ifm_read (output, 1), the byte stream to the IFM shift buffer.
REQ-011 SHALL have port ifm_row_start, output, 1, high with the ifm_read of column 0 of each row.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE, FETCH, DRAIN, DONE.
REQ-014 SHALL move IDLE->FETCH on start=1 when width and height are both nonzero, latching cfg_*; start outside IDLE SHALL be ignored.
REQ-015 SHALL move IDLE->DONE on start with width=0 or height=0, issuing no reads.
REQ-016 SHALL, in FETCH, issue sram_en=1 exactly on cycles with stall=0, in row-major order, address = base + row*width + col, from a running counter with no multiplier.
REQ-017 SHALL move FETCH->DRAIN on the cycle the last address (width*height-th) is issued.
REQ-018 SHALL compute addresses modulo 2^ADDR_W; wrap-around is legal and not flagged.
REQ-019 SHALL capture the returning byte into a one-entry skid register when stall=1 in its valid cycle; skid SHALL never overflow, since no address issues while stall=1.
REQ-020 SHALL register outputs: with stall=0, ifm_read<=skid_valid|rd_valid, and ifm_input<=skid if skid_valid else sram_rdata, clearing skid_valid; with stall=1, ifm_read<=0 and ifm_input holds.
REQ-021 SHALL give ifm_row_start the same pipeline and skid path as the data byte.
REQ-022 SHALL have a latency of 2 cycles from sram_en to ifm_read when stall=0.
REQ-023 SHALL move DRAIN->DONE after the final ifm_read is emitted and nothing is in flight or in skid.
REQ-024 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL set busy=1 in FETCH and DRAIN only.
REQ-026 SHALL emit exactly width*height ifm_read pulses per image, with no duplicates or drops under any stall pattern.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, enter IDLE and clear all counters, the skid entry and in-flight flags, and all outputs to 0.
REQ-028 SHALL discard any in-progress image on mid-operation reset, with no done pulse.

Structure
REQ-029 SHALL place the FSM state encoding and default ADDR_W/DIM_W in a shared package used by the IFM path.
REQ-030 SHALL implement the skid register plus output register as one sub-module, ifm_skid_stage; address generation and the FSM stay top-level.

Verification
REQ-031 SHALL verify 2x3 image, base=0x010, stall=0: 6 reads at 0x010..0x015, ifm_read 2 cycles after each sram_en, row_start on bytes 1 and 4, done 1 cycle after the last byte.
REQ-032 SHALL verify stall=1 for 3 cycles mid-row of a 4x4 image: byte order unchanged, no loss, total 16 ifm_read pulses.
REQ-033 SHALL verify start with width=0: no sram_en, done the following cycle, busy stays 0.
REQ-034 SHALL verify base=0xFFE, 2x2 image: addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-035 SHALL verify rst_n=0 during FETCH: all outputs 0 the next cycle, no done; a new start then streams correctly.
REQ-036 SHALL verify a second start while busy is ignored and the config is unchanged.
